// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard unit: one-bubble load-use stall, jump flush,
//            memory-busy freeze, registered EX operand forwarding selects and
//            saturating stall/flush event counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_write_reg,
    input  logic        ex_reg_wrenable,
    input  logic        ex_mem_to_reg,
    input  logic        ex_is_jump,
    input  logic        mem_busy,
    output logic        stall_if,
    output logic        bubble_ex,
    output logic        flush_id,
    output logic        freeze,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    localparam logic [1:0]  c_FWD_REGFILE = 2'b00;
    localparam logic [1:0]  c_FWD_MEM     = 2'b01;
    localparam logic [1:0]  c_FWD_WB      = 2'b10;
    localparam logic [15:0] c_COUNT_MAX   = 16'hFFFF;

    typedef enum logic [0:0] {
        RUN        = 1'b0,
        LOAD_STALL = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [4:0]  r_mem_wreg;
    logic        r_mem_wen;
    logic [4:0]  r_wb_wreg;
    logic        r_wb_wen;

    logic [1:0]  r_fwd_a;
    logic [1:0]  r_fwd_b;
    logic [15:0] r_stall_count;
    logic [15:0] r_flush_count;

    logic        w_load_use;
    logic        w_stall_if;
    logic        w_bubble_ex;
    logic        w_flush_id;
    logic        w_advance;
    logic [1:0]  w_fwd_a_next;
    logic [1:0]  w_fwd_b_next;
    logic [15:0] w_stall_count_next;
    logic [15:0] w_flush_count_next;

    // x0 is hard-wired zero, so a write to it never creates a dependency.
    function automatic logic src_match(
        input logic       used,
        input logic [4:0] src,
        input logic       wen,
        input logic [4:0] wreg
    );
        return used & wen & (wreg != 5'd0) & (wreg == src);
    endfunction

    // The instruction in EX is younger than the one in MEM, so it wins.
    function automatic logic [1:0] fwd_select(
        input logic       used,
        input logic [4:0] src,
        input logic       ex_wen,
        input logic [4:0] ex_wreg,
        input logic       mem_wen,
        input logic [4:0] mem_wreg
    );
        if (src_match(used, src, ex_wen, ex_wreg)) begin
            return c_FWD_MEM;
        end else if (src_match(used, src, mem_wen, mem_wreg)) begin
            return c_FWD_WB;
        end else begin
            return c_FWD_REGFILE;
        end
    endfunction

    assign freeze = mem_busy;

    assign w_load_use = ex_mem_to_reg &
                        (src_match(id_uses_rs1, id_rs1, ex_reg_wrenable, ex_write_reg) |
                         src_match(id_uses_rs2, id_rs2, ex_reg_wrenable, ex_write_reg));

    always_comb begin
        w_state_next = r_state;
        w_stall_if   = 1'b0;
        w_bubble_ex  = 1'b0;
        w_flush_id   = 1'b0;
        if (rst_n && !freeze) begin
            case (r_state)
                RUN: begin
                    if (ex_is_jump) begin
                        w_flush_id  = 1'b1;
                        w_bubble_ex = 1'b1;
                    end else if (w_load_use) begin
                        w_stall_if   = 1'b1;
                        w_bubble_ex  = 1'b1;
                        w_state_next = LOAD_STALL;
                    end
                end
                LOAD_STALL: begin
                    w_state_next = RUN;
                end
                default: begin
                    w_state_next = RUN;
                end
            endcase
        end
    end

    assign stall_if  = w_stall_if;
    assign bubble_ex = w_bubble_ex;
    assign flush_id  = w_flush_id;

    assign w_advance    = !freeze && !w_stall_if && !w_bubble_ex;
    assign w_fwd_a_next = fwd_select(id_uses_rs1, id_rs1, ex_reg_wrenable, ex_write_reg,
                                     r_mem_wen, r_mem_wreg);
    assign w_fwd_b_next = fwd_select(id_uses_rs2, id_rs2, ex_reg_wrenable, ex_write_reg,
                                     r_mem_wen, r_mem_wreg);

    // Counters are rewritten every cycle so a hold is an explicit self-copy.
    always_comb begin
        w_stall_count_next = r_stall_count;
        w_flush_count_next = r_flush_count;
        if (w_stall_if && (r_stall_count != c_COUNT_MAX)) begin
            w_stall_count_next = r_stall_count + 16'd1;
        end
        if (w_flush_id && (r_flush_count != c_COUNT_MAX)) begin
            w_flush_count_next = r_flush_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_mem_wreg    <= 5'd0;
            r_mem_wen     <= 1'b0;
            r_wb_wreg     <= 5'd0;
            r_wb_wen      <= 1'b0;
            r_fwd_a       <= c_FWD_REGFILE;
            r_fwd_b       <= c_FWD_REGFILE;
            r_stall_count <= 16'd0;
            r_flush_count <= 16'd0;
        end else begin
            r_state       <= w_state_next;
            r_stall_count <= w_stall_count_next;
            r_flush_count <= w_flush_count_next;
            if (!freeze) begin
                r_mem_wreg <= ex_write_reg;
                r_mem_wen  <= ex_reg_wrenable;
                r_wb_wreg  <= r_mem_wreg;
                r_wb_wen   <= r_mem_wen;
                if (w_bubble_ex) begin
                    r_fwd_a <= c_FWD_REGFILE;
                    r_fwd_b <= c_FWD_REGFILE;
                end else if (w_advance) begin
                    r_fwd_a <= w_fwd_a_next;
                    r_fwd_b <= w_fwd_b_next;
                end
            end
        end
    end

    assign fwd_a       = r_fwd_a;
    assign fwd_b       = r_fwd_b;
    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

    // The WB entry records retiring writers; nothing downstream consumes it yet.
    logic w_unused_wb;
    assign w_unused_wb = ^{r_wb_wreg, r_wb_wen};

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed self-checking bench for hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2;
    logic        id_uses_rs1, id_uses_rs2;
    logic [4:0]  ex_write_reg;
    logic        ex_reg_wrenable, ex_mem_to_reg, ex_is_jump;
    logic        mem_busy;
    logic        stall_if, bubble_ex, flush_id, freeze;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_count, flush_count;

    int checks   = 0;
    int failures = 0;

    hazard_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_write_reg    (ex_write_reg),
        .ex_reg_wrenable (ex_reg_wrenable),
        .ex_mem_to_reg   (ex_mem_to_reg),
        .ex_is_jump      (ex_is_jump),
        .mem_busy        (mem_busy),
        .stall_if        (stall_if),
        .bubble_ex       (bubble_ex),
        .flush_id        (flush_id),
        .freeze          (freeze),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] wr, input logic wen, input logic mtr, input logic jmp,
                         input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2);
        ex_write_reg    = wr;
        ex_reg_wrenable = wen;
        ex_mem_to_reg   = mtr;
        ex_is_jump      = jmp;
        id_rs1          = rs1;
        id_uses_rs1     = u1;
        id_rs2          = rs2;
        id_uses_rs2     = u2;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        mem_busy = 1'b0;
        drive(5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
        #1;
        checks++; if ({stall_if, bubble_ex, flush_id} !== 3'b000) begin failures++; $display("FAIL reset_ctrl: got %b expected 000", {stall_if, bubble_ex, flush_id}); end
        checks++; if (freeze !== 1'b0) begin failures++; $display("FAIL reset_freeze0: got %b expected 0", freeze); end
        mem_busy = 1'b1;
        #1;
        checks++; if (freeze !== 1'b1) begin failures++; $display("FAIL reset_freeze1: got %b expected 1", freeze); end
        mem_busy = 1'b0;
        tick();
        checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin failures++; $display("FAIL reset_fwd: got %b expected 0000", {fwd_a, fwd_b}); end
        checks++; if (stall_count !== 16'd0) begin failures++; $display("FAIL reset_stall_count: got %h expected 0000", stall_count); end
        checks++; if (flush_count !== 16'd0) begin failures++; $display("FAIL reset_flush_count: got %h expected 0000", flush_count); end
        tick();
        rst_n = 1'b1;
        drive(5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic test_load_use();
        drive(5'd5, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
        #1;
        checks++; if ({stall_if, bubble_ex, flush_id} !== 3'b110) begin failures++; $display("FAIL lu_stall: got %b expected 110", {stall_if, bubble_ex, flush_id}); end
        tick();
        checks++; if (fwd_a !== 2'b00) begin failures++; $display("FAIL lu_bubble_fwd: got %b expected 00", fwd_a); end
        checks++; if (stall_count !== 16'd1) begin failures++; $display("FAIL lu_count1: got %h expected 0001", stall_count); end
        drive(5'd5, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
        #1;
        checks++; if ({stall_if, bubble_ex} !== 2'b00) begin failures++; $display("FAIL lu_one_bubble: got %b expected 00", {stall_if, bubble_ex}); end
        tick();
        checks++; if (fwd_a !== 2'b10) begin failures++; $display("FAIL lu_fwd_a: got %b expected 10", fwd_a); end
        checks++; if (stall_count !== 16'd1) begin failures++; $display("FAIL lu_count_hold: got %h expected 0001", stall_count); end
        drive(5'd6, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1);
        #1;
        checks++; if (stall_if !== 1'b1) begin failures++; $display("FAIL lu_rs2_stall: got %b expected 1", stall_if); end
        tick();
        drive(5'd6, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1);
        tick();
        checks++; if (fwd_b !== 2'b10) begin failures++; $display("FAIL lu_fwd_b: got %b expected 10", fwd_b); end
        checks++; if (stall_count !== 16'd2) begin failures++; $display("FAIL lu_count2: got %h expected 0002", stall_count); end
    endtask

    task automatic test_alu_forward();
        drive(5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        #1;
        checks++; if ({stall_if, bubble_ex} !== 2'b00) begin failures++; $display("FAIL alu_no_stall: got %b expected 00", {stall_if, bubble_ex}); end
        tick();
        checks++; if (fwd_b !== 2'b01) begin failures++; $display("FAIL alu_fwd_b_ex: got %b expected 01", fwd_b); end
        drive(5'd9, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 5'd3, 1'b1);
        tick();
        checks++; if (fwd_b !== 2'b10) begin failures++; $display("FAIL alu_fwd_b_mem: got %b expected 10", fwd_b); end
        checks++; if (fwd_a !== 2'b01) begin failures++; $display("FAIL alu_fwd_a_ex: got %b expected 01", fwd_a); end
        drive(5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        drive(5'd4, 1'b1, 1'b0, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0);
        tick();
        checks++; if (fwd_a !== 2'b01) begin failures++; $display("FAIL alu_newest_wins: got %b expected 01", fwd_a); end
        drive(5'd0, 1'b0, 1'b0, 1'b0, 5'd4, 1'b0, 5'd0, 1'b0);
        tick();
        checks++; if (fwd_a !== 2'b00) begin failures++; $display("FAIL alu_unused_src: got %b expected 00", fwd_a); end
    endtask

    task automatic test_jump();
        drive(5'd8, 1'b1, 1'b1, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0);
        #1;
        checks++; if ({stall_if, bubble_ex, flush_id} !== 3'b011) begin failures++; $display("FAIL jump_ctrl: got %b expected 011", {stall_if, bubble_ex, flush_id}); end
        tick();
        checks++; if (flush_count !== 16'd1) begin failures++; $display("FAIL jump_flush_count: got %h expected 0001", flush_count); end
        checks++; if (stall_count !== 16'd2) begin failures++; $display("FAIL jump_stall_count: got %h expected 0002", stall_count); end
        checks++; if (fwd_a !== 2'b00) begin failures++; $display("FAIL jump_fwd: got %b expected 00", fwd_a); end
        drive(5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        checks++; if (flush_id !== 1'b0) begin failures++; $display("FAIL jump_after: got %b expected 0", flush_id); end
        tick();
    endtask

    task automatic test_x0_disabled();
        drive(5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0);
        #1;
        checks++; if (stall_if !== 1'b0) begin failures++; $display("FAIL x0_stall: got %b expected 0", stall_if); end
        tick();
        checks++; if (fwd_a !== 2'b00) begin failures++; $display("FAIL x0_fwd: got %b expected 00", fwd_a); end
        drive(5'd7, 1'b0, 1'b1, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0);
        #1;
        checks++; if (stall_if !== 1'b0) begin failures++; $display("FAIL wen0_stall: got %b expected 0", stall_if); end
        tick();
        checks++; if (fwd_a !== 2'b00) begin failures++; $display("FAIL wen0_fwd: got %b expected 00", fwd_a); end
        drive(5'd0, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0);
        tick();
        checks++; if (fwd_a !== 2'b00) begin failures++; $display("FAIL wen0_mem_fwd: got %b expected 00", fwd_a); end
    endtask

    task automatic test_freeze();
        drive(5'd10, 1'b1, 1'b1, 1'b0, 5'd10, 1'b1, 5'd0, 1'b0);
        #1;
        checks++; if (stall_if !== 1'b1) begin failures++; $display("FAIL frz_setup: got %b expected 1", stall_if); end
        tick();
        mem_busy = 1'b1;
        drive(5'd11, 1'b1, 1'b1, 1'b1, 5'd11, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({freeze, stall_if, bubble_ex, flush_id} !== 4'b1000) begin failures++; $display("FAIL frz_ctrl[%0d]: got %b expected 1000", i, {freeze, stall_if, bubble_ex, flush_id}); end
            tick();
            checks++; if ({fwd_a, stall_count, flush_count} !== {2'b00, 16'd3, 16'd1}) begin failures++; $display("FAIL frz_hold[%0d]: got %h expected %h", i, {fwd_a, stall_count, flush_count}, {2'b00, 16'd3, 16'd1}); end
        end
        mem_busy = 1'b0;
        drive(5'd12, 1'b1, 1'b1, 1'b0, 5'd10, 1'b1, 5'd12, 1'b1);
        #1;
        checks++; if ({freeze, stall_if, bubble_ex} !== 3'b000) begin failures++; $display("FAIL frz_release: got %b expected 000", {freeze, stall_if, bubble_ex}); end
        tick();
        checks++; if ({fwd_a, fwd_b} !== 4'b1001) begin failures++; $display("FAIL frz_fwd: got %b expected 1001", {fwd_a, fwd_b}); end
        drive(5'd13, 1'b1, 1'b1, 1'b0, 5'd13, 1'b1, 5'd0, 1'b0);
        #1;
        checks++; if (stall_if !== 1'b1) begin failures++; $display("FAIL frz_back_to_run: got %b expected 1", stall_if); end
        tick();
        checks++; if (stall_count !== 16'd4) begin failures++; $display("FAIL frz_count: got %h expected 0004", stall_count); end
        drive(5'd13, 1'b0, 1'b0, 1'b0, 5'd13, 1'b1, 5'd0, 1'b0);
        tick();
        drive(5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic test_saturation();
        force dut.r_stall_count = 16'hFFFE;
        tick();
        release dut.r_stall_count;
        #1;
        checks++; if (stall_count !== 16'hFFFE) begin failures++; $display("FAIL sat_preload: got %h expected fffe", stall_count); end
        drive(5'd14, 1'b1, 1'b1, 1'b0, 5'd14, 1'b1, 5'd0, 1'b0);
        tick();
        checks++; if (stall_count !== 16'hFFFF) begin failures++; $display("FAIL sat_first: got %h expected ffff", stall_count); end
        drive(5'd14, 1'b0, 1'b0, 1'b0, 5'd14, 1'b1, 5'd0, 1'b0);
        tick();
        drive(5'd15, 1'b1, 1'b1, 1'b0, 5'd15, 1'b1, 5'd0, 1'b0);
        #1;
        checks++; if (stall_if !== 1'b1) begin failures++; $display("FAIL sat_second_stall: got %b expected 1", stall_if); end
        tick();
        checks++; if (stall_count !== 16'hFFFF) begin failures++; $display("FAIL sat_hold: got %h expected ffff", stall_count); end
        checks++; if (flush_count !== 16'd1) begin failures++; $display("FAIL sat_flush: got %h expected 0001", flush_count); end
    endtask

    task automatic test_reset_mid_stall();
        rst_n = 1'b0;
        drive(5'd16, 1'b1, 1'b1, 1'b1, 5'd16, 1'b1, 5'd0, 1'b0);
        #1;
        checks++; if ({stall_if, bubble_ex, flush_id} !== 3'b000) begin failures++; $display("FAIL rst_mid_ctrl: got %b expected 000", {stall_if, bubble_ex, flush_id}); end
        tick();
        checks++; if ({fwd_a, fwd_b, stall_count, flush_count} !== 36'd0) begin failures++; $display("FAIL rst_mid_regs: got %h expected 0", {fwd_a, fwd_b, stall_count, flush_count}); end
        rst_n = 1'b1;
        drive(5'd17, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd17, 1'b1);
        #1;
        checks++; if (stall_if !== 1'b1) begin failures++; $display("FAIL rst_run_after: got %b expected 1", stall_if); end
        tick();
        checks++; if (stall_count !== 16'd1) begin failures++; $display("FAIL rst_count_restart: got %h expected 0001", stall_count); end
        rst_n = 1'b0;
        drive(5'd16, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        rst_n = 1'b1;
        drive(5'd0, 1'b0, 1'b0, 1'b0, 5'd16, 1'b1, 5'd0, 1'b0);
        tick();
        checks++; if (fwd_a !== 2'b00) begin failures++; $display("FAIL rst_tracker_clear: got %b expected 00", fwd_a); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_alu_forward();
        test_jump();
        test_x0_disabled();
        test_freeze();
        test_saturation();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected summary");
        $fatal(1);
    end

endmodule
`default_nettype wire
